register_bank: RTL and testbench
================================

REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 Parameter DATA_W, default 16, data word width in bits.
REQ-002 Parameter ADDR_W, default 4, register address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter ZERO_REG, default 1, when 1 register 0 is hardwired to zero and never pending.
REQ-004 One clock; reset is synchronous and active-high; ports named clock and reset.
REQ-005 clock  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 rs_addr  input  ADDR_W  read port A address.
REQ-008 rt_addr  input  ADDR_W  read port B address.
REQ-009 rd_en  input  1  capture enable for both read ports.
REQ-010 rs  output  DATA_W  registered read data, port A.
REQ-011 rt  output  DATA_W  registered read data, port B.
REQ-012 rs_pending  output  1  registered pending flag for rs_addr.
REQ-013 rt_pending  output  1  registered pending flag for rt_addr.
REQ-014 write_addr  input  ADDR_W  write address.
REQ-015 write_data  input  DATA_W  write data.
REQ-016 reg_write  input  1  write enable.
REQ-017 rsv_en  input  1  reserve request: mark rsv_addr pending.
REQ-018 rsv_addr  input  ADDR_W  register to reserve.
REQ-019 pending_count  output  ADDR_W+1  registered count of pending registers.

Function
REQ-020 Write: reg_write=1 at rising edge stores write_data into write_addr; ignored when ZERO_REG=1 and write_addr=0.
REQ-021 Read latency is one cycle: rd_en=1 at edge N updates rs/rt/rs_pending/rt_pending, visible after edge N.
REQ-022 rd_en=0: rs, rt, rs_pending, rt_pending hold their previous values.
REQ-023 Write-through bypass: if reg_write=1 and write_addr equals a read address in the same cycle (and write is not discarded per REQ-020), that port captures write_data, not the stored value.
REQ-024 ZERO_REG=1: a read of address 0 captures 0 regardless of any same-cycle write.
REQ-025 Pending state: one bit per register; rsv_en sets bit rsv_addr; reg_write clears bit write_addr.
REQ-026 Same cycle rsv_en and reg_write to the same address: set wins, bit ends at 1.
REQ-027 ZERO_REG=1: reservation of address 0 is ignored; bit 0 is constant 0.
REQ-028 rs_pending/rt_pending capture the next-state pending bit of their address (after REQ-025..027 are applied).
REQ-029 Reserving an already-pending register leaves it pending; writing a non-pending register leaves it non-pending; neither is an error.
REQ-030 pending_count equals the population count of the next-state pending vector, registered every cycle; max DEPTH (or DEPTH-1 with ZERO_REG=1), never wraps.
REQ-031 rs_addr = rt_addr is legal; both ports return identical data and flags.

Reset
REQ-032 reset=1 at an edge clears all registers, all pending bits, rs, rt, rs_pending, rt_pending and pending_count to 0.
REQ-033 reset overrides reg_write, rsv_en and rd_en in the same cycle; no write or reservation issued during reset takes effect.
REQ-034 First cycle after reset deasserts operates normally with no residual state.

Verification
REQ-035 Reset, then write 0x1234 to r5, next cycle rd_en with rs_addr=5 -> rs=0x1234 one cycle later.
REQ-036 Same cycle reg_write r7=0xBEEF and rd_en rs_addr=rt_addr=7 -> rs=rt=0xBEEF after the edge.
REQ-037 ZERO_REG=1: write 0xFFFF to r0, read r0 same and next cycle -> rs=0x0000 both times; rsv_en r0 -> pending_count stays 0.
REQ-038 rsv_en r3, then rsv_en r4 -> pending_count 1 then 2; reg_write r3 with rsv_en r3 same cycle -> r3 stays pending, count 2; reg_write r4 -> count 1.
REQ-039 rd_en=0 while r5 is rewritten -> rs holds old value; rd_en=1 -> new value appears.
REQ-040 Populate r1..r15 and reserve r2, assert reset mid-stream with reg_write=1 -> all reads return 0, pending_count=0, the concurrent write is lost.

Source files
------------

// File: rtl/register_bank_if.sv
// Bus bundle for register_bank: two read ports, one write port, reservation
// port and the pending-count readout.
interface register_bank_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
);
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic              rd_en;
  logic [DATA_W-1:0] rs;
  logic [DATA_W-1:0] rt;
  logic              rs_pending;
  logic              rt_pending;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic              reg_write;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic [ADDR_W:0]   pending_count;

  modport master (
    output rs_addr, rt_addr, rd_en, write_addr, write_data, reg_write,
           rsv_en, rsv_addr,
    input  rs, rt, rs_pending, rt_pending, pending_count
  );

  modport slave (
    input  rs_addr, rt_addr, rd_en, write_addr, write_data, reg_write,
           rsv_en, rsv_addr,
    output rs, rt, rs_pending, rt_pending, pending_count
  );
endinterface

// File: rtl/register_bank.sv
// Two-read/one-write register file with write-through bypass and a per-register
// pending (scoreboard) bit plus a registered population count of pending bits.
module register_bank #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned ZERO_REG = 1
) (
  input logic             clock,
  input logic             reset,
  register_bank_if.slave  bus
);
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam bit          ZR    = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  pending_q, pending_d;
  logic [DATA_W-1:0] rs_q, rs_d, rt_q, rt_d;
  logic              rs_pend_q, rs_pend_d, rt_pend_q, rt_pend_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              wr_ok;

  // Next-state pending vector: clear on write, then set on reserve so set wins.
  always_comb begin
    wr_ok     = bus.reg_write && !(ZR && (bus.write_addr == '0));
    pending_d = pending_q;
    if (bus.reg_write) pending_d[bus.write_addr] = 1'b0;
    if (bus.rsv_en)    pending_d[bus.rsv_addr]   = 1'b1;
    if (ZR)            pending_d[0]              = 1'b0;
    count_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      count_d = count_d + CNT_W'(pending_d[i]);
    end
  end

  // Read data with same-cycle write bypass; register 0 reads as zero when hardwired.
  always_comb begin
    rs_d = regs_q[bus.rs_addr];
    rt_d = regs_q[bus.rt_addr];
    if (wr_ok && (bus.write_addr == bus.rs_addr)) rs_d = bus.write_data;
    if (wr_ok && (bus.write_addr == bus.rt_addr)) rt_d = bus.write_data;
    if (ZR && (bus.rs_addr == '0)) rs_d = '0;
    if (ZR && (bus.rt_addr == '0)) rt_d = '0;
    rs_pend_d = pending_d[bus.rs_addr];
    rt_pend_d = pending_d[bus.rt_addr];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      pending_q <= '0;
      count_q   <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rs_pend_q <= 1'b0;
      rt_pend_q <= 1'b0;
    end else begin
      if (wr_ok) regs_q[bus.write_addr] <= bus.write_data;
      pending_q <= pending_d;
      count_q   <= count_d;
      if (bus.rd_en) begin
        rs_q      <= rs_d;
        rt_q      <= rt_d;
        rs_pend_q <= rs_pend_d;
        rt_pend_q <= rt_pend_d;
      end
    end
  end

  assign bus.rs            = rs_q;
  assign bus.rt            = rt_q;
  assign bus.rs_pending    = rs_pend_q;
  assign bus.rt_pending    = rt_pend_q;
  assign bus.pending_count = count_q;
endmodule

// File: tb/tb_register_bank.sv
// Directed-vector bench for register_bank with hand-computed expectations.
module tb_register_bank;
  logic clock;
  logic reset;
  int   n_vec;
  int   n_err;

  register_bank_if #(.DATA_W(16), .ADDR_W(4)) bus ();

  register_bank #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.rd_en      = 1'b0;
    bus.reg_write  = 1'b0;
    bus.rsv_en     = 1'b0;
    bus.rs_addr    = '0;
    bus.rt_addr    = '0;
    bus.write_addr = '0;
    bus.write_data = '0;
    bus.rsv_addr   = '0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    bus.reg_write  = 1'b1;
    bus.write_addr = a;
    bus.write_data = d;
  endtask

  task automatic rd(input logic [3:0] a, input logic [3:0] b);
    bus.rd_en   = 1'b1;
    bus.rs_addr = a;
    bus.rt_addr = b;
  endtask

  task automatic rsv(input logic [3:0] a);
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = a;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_rs", 32'(bus.rs), 32'h0);
    chk("rst_rt", 32'(bus.rt), 32'h0);
    chk("rst_rs_pend", 32'(bus.rs_pending), 32'h0);
    chk("rst_count", 32'(bus.pending_count), 32'h0);

    // Write then read one cycle later
    wr(4'd5, 16'h1234); tick(); idle();
    rd(4'd5, 4'd0); tick(); idle();
    chk("r5_read", 32'(bus.rs), 32'h1234);
    chk("r0_portb", 32'(bus.rt), 32'h0);

    // Same-cycle bypass to both ports
    wr(4'd7, 16'hBEEF); rd(4'd7, 4'd7); tick(); idle();
    chk("byp_rs", 32'(bus.rs), 32'hBEEF);
    chk("byp_rt", 32'(bus.rt), 32'hBEEF);

    // Hold while rd_en is low
    wr(4'd5, 16'h5555); bus.rs_addr = 4'd5; tick(); idle();
    chk("hold_rs", 32'(bus.rs), 32'hBEEF);
    rd(4'd5, 4'd7); tick(); idle();
    chk("after_hold_rs", 32'(bus.rs), 32'h5555);
    chk("after_hold_rt", 32'(bus.rt), 32'hBEEF);

    // Hardwired register 0
    wr(4'd0, 16'hFFFF); rd(4'd0, 4'd0); tick(); idle();
    chk("r0_same", 32'(bus.rs), 32'h0);
    rd(4'd0, 4'd0); tick(); idle();
    chk("r0_next", 32'(bus.rs), 32'h0);
    rsv(4'd0); rd(4'd0, 4'd0); tick(); idle();
    chk("r0_rsv_count", 32'(bus.pending_count), 32'h0);
    chk("r0_rsv_pend", 32'(bus.rs_pending), 32'h0);

    // Pending scoreboard
    rsv(4'd3); tick(); idle();
    chk("cnt_r3", 32'(bus.pending_count), 32'd1);
    rsv(4'd4); tick(); idle();
    chk("cnt_r4", 32'(bus.pending_count), 32'd2);
    rsv(4'd3); wr(4'd3, 16'h3333); rd(4'd3, 4'd4); tick(); idle();
    chk("set_wins_cnt", 32'(bus.pending_count), 32'd2);
    chk("set_wins_pend", 32'(bus.rs_pending), 32'd1);
    chk("set_wins_data", 32'(bus.rs), 32'h3333);
    chk("r4_pend", 32'(bus.rt_pending), 32'd1);
    wr(4'd4, 16'h4444); rd(4'd3, 4'd4); tick(); idle();
    chk("clr_r4_cnt", 32'(bus.pending_count), 32'd1);
    chk("clr_r4_pend", 32'(bus.rt_pending), 32'd0);
    chk("clr_r4_data", 32'(bus.rt), 32'h4444);
    rsv(4'd3); tick(); idle();
    chk("re_rsv_cnt", 32'(bus.pending_count), 32'd1);

    // Populate r1..r15 (clears r3), reserve r2
    for (int i = 1; i < 16; i++) begin
      wr(4'(i), 16'(i * 'h111)); tick();
    end
    idle();
    chk("pop_cnt", 32'(bus.pending_count), 32'd0);
    rsv(4'd2); rd(4'd9, 4'd2); tick(); idle();
    chk("pop_r9", 32'(bus.rs), 32'h0999);
    chk("pop_r2", 32'(bus.rt), 32'h0222);
    chk("pop_r2_pend", 32'(bus.rt_pending), 32'd1);
    chk("pop_cnt2", 32'(bus.pending_count), 32'd1);

    // Reset overrides a concurrent write, reservation and read
    reset = 1'b1; wr(4'd9, 16'hAAAA); rsv(4'd6); rd(4'd9, 4'd9); tick();
    reset = 1'b0; idle();
    chk("rst_mid_rs", 32'(bus.rs), 32'h0);
    chk("rst_mid_cnt", 32'(bus.pending_count), 32'd0);
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), 4'(15 - i)); tick(); idle();
      chk($sformatf("post_rst_rs%0d", i), 32'(bus.rs), 32'h0);
      chk($sformatf("post_rst_rt%0d", 15 - i), 32'(bus.rt), 32'h0);
      chk($sformatf("post_rst_pend%0d", i), 32'({bus.rs_pending, bus.rt_pending}), 32'h0);
    end
    chk("post_rst_cnt", 32'(bus.pending_count), 32'd0);

    // Normal operation right after reset
    wr(4'd9, 16'h0BAD); rsv(4'd6); rd(4'd9, 4'd6); tick(); idle();
    chk("post_rst_wr", 32'(bus.rs), 32'h0BAD);
    chk("post_rst_rsv", 32'(bus.rt_pending), 32'd1);
    chk("post_rst_cnt1", 32'(bus.pending_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
